// File: rtl/wino_io_pkg.sv
// Shared widths, derived beat counts and serialiser state type for the
// pad serdes layer in front of the Winograd core.
package wino_io_pkg;

    localparam int D_W_DEF         = 80;
    localparam int Z_W_DEF         = 40;
    localparam int PIN_W_DEF       = 16;
    localparam int POUT_W_DEF      = 8;
    localparam int OFIFO_DEPTH_DEF = 4;

    localparam int NIN  = D_W_DEF / PIN_W_DEF;
    localparam int NOUT = Z_W_DEF / POUT_W_DEF;

    // A counter over n values still needs one bit when n == 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IN_CNT_W  = cnt_w(NIN);
    localparam int OUT_CNT_W = cnt_w(NOUT);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO whose head word sits in a register fed by a registered
// read of the storage array; empty clears one cycle after the first write.
module io_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] data_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    rd_idx;
    logic [CW-1:0]    count_reg;
    logic             head_vld_reg;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok   = pop && head_vld_reg;
    assign full     = (count_reg == CW'(DEPTH));
    assign push_ok  = push && (!full || pop_ok);
    assign rd_idx   = rd_ptr_reg + PW'(pop_ok);
    assign pop_data = data_reg;
    assign empty    = !head_vld_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        data_reg <= mem[rd_idx];
    end

    // The head register is valid only for words written before this edge,
    // since the array read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_vld_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg   <= rd_idx;
            count_reg    <= count_reg + CW'(push_ok) - CW'(pop_ok);
            head_vld_reg <= ((count_reg - CW'(pop_ok)) != '0);
        end
    end

endmodule

// File: rtl/wino_pad_serdes.sv
// Pad-count reduction layer: assembles narrow input beats into core D words
// and serialises buffered core Z words onto a narrow handshaked output bus.
module wino_pad_serdes
    import wino_io_pkg::*;
#(
    parameter int D_W         = D_W_DEF,
    parameter int Z_W         = Z_W_DEF,
    parameter int PIN_W       = PIN_W_DEF,
    parameter int POUT_W      = POUT_W_DEF,
    parameter int OFIFO_DEPTH = OFIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIN_W-1:0]  pad_din,
    input  logic              pad_din_vld,
    input  logic              pad_din_sof,
    output logic [D_W-1:0]    core_d,
    output logic              core_d_vld,
    input  logic [Z_W-1:0]    core_z,
    input  logic              core_z_vld,
    output logic [POUT_W-1:0] pad_dout,
    output logic              pad_dout_vld,
    output logic              pad_dout_sof,
    input  logic              pad_dout_rdy,
    output logic              ofifo_ovf,
    output logic              in_frame_err
);
    localparam int N_IN  = D_W / PIN_W;
    localparam int N_OUT = Z_W / POUT_W;
    localparam int ICW   = cnt_w(N_IN);
    localparam int OCW   = cnt_w(N_OUT);

    logic [ICW-1:0]  in_cnt_reg;
    logic [ICW-1:0]  in_cnt_next;
    logic [N_IN-1:0] beat_we;
    logic            word_done_reg;
    logic            word_done_next;
    logic            frame_err_set;
    logic [D_W-1:0]  asm_word;

    always_comb begin
        in_cnt_next    = in_cnt_reg;
        beat_we        = '0;
        word_done_next = 1'b0;
        frame_err_set  = 1'b0;
        if (pad_din_vld) begin
            if (pad_din_sof) begin
                beat_we[0]    = 1'b1;
                frame_err_set = (in_cnt_reg != '0);
                if (N_IN == 1) begin
                    word_done_next = 1'b1;
                    in_cnt_next    = '0;
                end else begin
                    in_cnt_next = ICW'(1);
                end
            end else if (in_cnt_reg == '0) begin
                frame_err_set = 1'b1;
            end else begin
                beat_we[in_cnt_reg] = 1'b1;
                if (in_cnt_reg == ICW'(N_IN - 1)) begin
                    word_done_next = 1'b1;
                    in_cnt_next    = '0;
                end else begin
                    in_cnt_next = in_cnt_reg + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_beat
        logic [PIN_W-1:0] beat_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                beat_reg <= '0;
            end else if (beat_we[gi]) begin
                beat_reg <= pad_din;
            end
        end
        assign asm_word[gi*PIN_W +: PIN_W] = beat_reg;
    end

    // The completed word is copied one edge after its last beat, so a new
    // sof beat arriving on that edge cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_reg    <= '0;
            word_done_reg <= 1'b0;
            core_d        <= '0;
            core_d_vld    <= 1'b0;
            in_frame_err  <= 1'b0;
        end else begin
            in_cnt_reg    <= in_cnt_next;
            word_done_reg <= word_done_next;
            core_d_vld    <= word_done_reg;
            if (word_done_reg) begin
                core_d <= asm_word;
            end
            if (frame_err_set) begin
                in_frame_err <= 1'b1;
            end
        end
    end

    ser_state_t      state_reg;
    logic [Z_W-1:0]  shift_reg;
    logic [Z_W-1:0]  shift_next;
    logic [OCW-1:0]  out_cnt_reg;
    logic [Z_W-1:0]  fifo_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            beat_xfer;
    logic            last_beat;

    assign beat_xfer  = (state_reg == SEND) && pad_dout_rdy;
    assign last_beat  = (out_cnt_reg == OCW'(N_OUT - 1));
    assign fifo_pop   = !fifo_empty && ((state_reg == IDLE) || (beat_xfer && last_beat));
    assign shift_next = shift_reg >> POUT_W;

    io_sync_fifo #(
        .WIDTH (Z_W),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .push      (core_z_vld),
        .push_data (core_z),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            out_cnt_reg  <= '0;
            pad_dout     <= '0;
            pad_dout_vld <= 1'b0;
            pad_dout_sof <= 1'b0;
            ofifo_ovf    <= 1'b0;
        end else begin
            if (core_z_vld && fifo_full && !fifo_pop) begin
                ofifo_ovf <= 1'b1;
            end
            if (fifo_pop) begin
                // Covers both the idle start and the bubble-free reload.
                state_reg    <= SEND;
                shift_reg    <= fifo_data;
                out_cnt_reg  <= '0;
                pad_dout     <= fifo_data[POUT_W-1:0];
                pad_dout_vld <= 1'b1;
                pad_dout_sof <= 1'b1;
            end else if (beat_xfer) begin
                if (last_beat) begin
                    state_reg    <= IDLE;
                    pad_dout_vld <= 1'b0;
                    pad_dout_sof <= 1'b0;
                end else begin
                    out_cnt_reg  <= out_cnt_reg + 1'b1;
                    shift_reg    <= shift_next;
                    pad_dout     <= shift_next[POUT_W-1:0];
                    pad_dout_sof <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wino_pad_serdes.sv
// Self-checking bench for wino_pad_serdes at default widths: vector table for
// input framing, directed output sequences, and randomized model checks.
module tb_wino_pad_serdes;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pad_din;
    logic        pad_din_vld;
    logic        pad_din_sof;
    logic [79:0] core_d;
    logic        core_d_vld;
    logic [39:0] core_z;
    logic        core_z_vld;
    logic [7:0]  pad_dout;
    logic        pad_dout_vld;
    logic        pad_dout_sof;
    logic        pad_dout_rdy;
    logic        ofifo_ovf;
    logic        in_frame_err;

    wino_pad_serdes dut (
        .clk          (clk),
        .rst          (rst),
        .pad_din      (pad_din),
        .pad_din_vld  (pad_din_vld),
        .pad_din_sof  (pad_din_sof),
        .core_d       (core_d),
        .core_d_vld   (core_d_vld),
        .core_z       (core_z),
        .core_z_vld   (core_z_vld),
        .pad_dout     (pad_dout),
        .pad_dout_vld (pad_dout_vld),
        .pad_dout_sof (pad_dout_sof),
        .pad_dout_rdy (pad_dout_rdy),
        .ofifo_ovf    (ofifo_ovf),
        .in_frame_err (in_frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Output-side scoreboard: words expected on the pad bus, in order.
    logic [39:0] exp_q[$];
    logic [39:0] acc;
    int          asm_idx = 0;

    typedef struct {
        logic        vld;
        logic        sof;
        logic [15:0] din;
        logic        exp_vld;
        logic [79:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic s, input logic [15:0] d,
                                input logic ev, input logic [79:0] ed, input logic ee);
        vec_t r;
        r.vld = v; r.sof = s; r.din = d; r.exp_vld = ev; r.exp_d = ed; r.exp_err = ee;
        return r;
    endfunction

    function automatic logic [39:0] rnd40();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    // One clock: note pad state before the edge, then verify hold behaviour
    // and feed accepted beats to the word reassembler.
    task automatic cycle();
        logic       pv, ps, xfer, in_rst;
        logic [7:0] pd;
        pv     = pad_dout_vld;
        ps     = pad_dout_sof;
        pd     = pad_dout;
        xfer   = pv && pad_dout_rdy;
        in_rst = rst;
        @(posedge clk);
        #1;
        if (!in_rst && pv && !pad_dout_rdy) begin
            chk("hold_vld", pad_dout_vld, 1);
            chk("hold_dout", pad_dout, pd);
            chk("hold_sof", pad_dout_sof, ps);
        end
        if (!in_rst && xfer) begin
            chk("sof_flag", ps, asm_idx == 0);
            if (ps) asm_idx = 0;
            acc[asm_idx*8 +: 8] = pd;
            asm_idx++;
            if (asm_idx == 5) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL z_word: got %h expected no word", acc);
                end else begin
                    chk("z_word", acc, exp_q.pop_front());
                end
                asm_idx = 0;
            end
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        asm_idx = 0;
    endtask

    initial begin
        logic [7:0]  beats[5];
        logic [15:0] mq[$];
        logic [79:0] exp_d, word_prev, word_now;
        logic [39:0] zw;
        bit          done_prev, done_now, err_exp, seen;

        rst = 1'b1; pad_din = '0; pad_din_vld = 0; pad_din_sof = 0;
        core_z = '0; core_z_vld = 0; pad_dout_rdy = 0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_core_d", core_d, 0);
        chk("rst_core_d_vld", core_d_vld, 0);
        chk("rst_pad_dout", pad_dout, 0);
        chk("rst_pad_vld", pad_dout_vld, 0);
        chk("rst_pad_sof", pad_dout_sof, 0);
        chk("rst_ovf", ofifo_ovf, 0);
        chk("rst_err", in_frame_err, 0);

        // Clean word, then a truncated word restarted by sof.
        tbl[0]  = mk(1, 1, 16'h0001, 0, 80'h0, 0);
        tbl[1]  = mk(1, 0, 16'h0002, 0, 80'h0, 0);
        tbl[2]  = mk(1, 0, 16'h0003, 0, 80'h0, 0);
        tbl[3]  = mk(1, 0, 16'h0004, 0, 80'h0, 0);
        tbl[4]  = mk(1, 0, 16'h0005, 0, 80'h0, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 1, 80'h0005_0004_0003_0002_0001, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 80'h0005_0004_0003_0002_0001, 0);
        tbl[7]  = mk(1, 1, 16'h00A1, 0, 80'h0005_0004_0003_0002_0001, 0);
        tbl[8]  = mk(1, 0, 16'h00A2, 0, 80'h0005_0004_0003_0002_0001, 0);
        tbl[9]  = mk(1, 0, 16'h00A3, 0, 80'h0005_0004_0003_0002_0001, 0);
        tbl[10] = mk(1, 1, 16'h00B1, 0, 80'h0005_0004_0003_0002_0001, 1);
        tbl[11] = mk(1, 0, 16'h00B2, 0, 80'h0005_0004_0003_0002_0001, 1);
        tbl[12] = mk(1, 0, 16'h00B3, 0, 80'h0005_0004_0003_0002_0001, 1);
        tbl[13] = mk(1, 0, 16'h00B4, 0, 80'h0005_0004_0003_0002_0001, 1);
        tbl[14] = mk(1, 0, 16'h00B5, 0, 80'h0005_0004_0003_0002_0001, 1);
        tbl[15] = mk(0, 0, 16'h0000, 1, 80'h00B5_00B4_00B3_00B2_00B1, 1);
        tbl[16] = mk(0, 0, 16'h0000, 0, 80'h00B5_00B4_00B3_00B2_00B1, 1);
        for (int i = 0; i < 17; i++) begin
            pad_din_vld = tbl[i].vld;
            pad_din_sof = tbl[i].sof;
            pad_din     = tbl[i].din;
            cycle();
            chk($sformatf("tbl%0d_vld", i), core_d_vld, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_d", i), core_d, tbl[i].exp_d);
            chk($sformatf("tbl%0d_err", i), in_frame_err, tbl[i].exp_err);
        end
        pad_din_vld = 0; pad_din_sof = 0;

        // Single Z word: latency E+2, little-endian beats, sof on the first.
        beats[0] = 8'h9A; beats[1] = 8'h78; beats[2] = 8'h56; beats[3] = 8'h34; beats[4] = 8'h12;
        pad_dout_rdy = 1;
        zw = 40'h12_3456_789A;
        exp_q.push_back(zw);
        core_z = zw; core_z_vld = 1;
        cycle();
        core_z_vld = 0;
        chk("lat_e0_vld", pad_dout_vld, 0);
        cycle();
        chk("lat_e1_vld", pad_dout_vld, 0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("seq_vld", pad_dout_vld, 1);
            chk("seq_beat", pad_dout, beats[k]);
            chk("seq_sof", pad_dout_sof, k == 0);
            cycle();
        end
        chk("seq_end_vld", pad_dout_vld, 0);

        // Three-cycle stall in the middle of a word.
        pad_dout_rdy = 0;
        zw = rnd40();
        exp_q.push_back(zw);
        core_z = zw; core_z_vld = 1;
        cycle();
        core_z_vld = 0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (pad_dout_vld) seen = 1;
            else cycle();
        end
        chk("stall_start_seen", seen, 1);
        pad_dout_rdy = 1;
        cycle();
        cycle();
        pad_dout_rdy = 0;
        for (int t = 0; t < 3; t++) cycle();
        pad_dout_rdy = 1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle();
        chk("stall_drained", exp_q.size(), 0);

        // Random push/ready traffic without overflow.
        for (int i = 0; i < 400; i++) begin
            pad_dout_rdy = 1'($urandom_range(0, 1));
            if (exp_q.size() < 4 && $urandom_range(0, 3) == 0) begin
                zw = rnd40();
                exp_q.push_back(zw);
                core_z = zw; core_z_vld = 1;
            end else begin
                core_z_vld = 0;
            end
            cycle();
        end
        core_z_vld = 0;
        pad_dout_rdy = 1;
        for (int t = 0; t < 60 && (exp_q.size() != 0 || pad_dout_vld); t++) cycle();
        chk("rnd_out_drained", exp_q.size(), 0);
        chk("rnd_out_no_ovf", ofifo_ovf, 0);

        // Overflow: one word held by the serialiser, four fill the FIFO, sixth dropped.
        pad_dout_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            zw = rnd40();
            if (i < 5) exp_q.push_back(zw);
            core_z = zw; core_z_vld = 1;
            cycle();
            if (i == 4) chk("ovf_not_yet", ofifo_ovf, 0);
        end
        core_z_vld = 0;
        chk("ovf_set", ofifo_ovf, 1);
        cycle();
        cycle();
        pad_dout_rdy = 1;
        for (int t = 0; t < 25; t++) begin
            chk("b2b_vld", pad_dout_vld, 1);
            cycle();
        end
        chk("b2b_end_vld", pad_dout_vld, 0);
        chk("b2b_all_words", exp_q.size(), 0);
        chk("ovf_sticky", ofifo_ovf, 1);

        // Reset in the middle of an input word and an output word.
        pad_din_vld = 1; pad_din_sof = 1; pad_din = 16'h0C01;
        cycle();
        pad_din_sof = 0; pad_din = 16'h0C02;
        cycle();
        pad_din_vld = 0;
        pad_dout_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            zw = rnd40();
            exp_q.push_back(zw);
            core_z = zw; core_z_vld = 1;
            cycle();
        end
        core_z_vld = 0;
        cycle();
        cycle();
        chk("pre_rst_vld", pad_dout_vld, 1);
        reset_pulse();
        chk("mid_rst_core_d", core_d, 0);
        chk("mid_rst_core_d_vld", core_d_vld, 0);
        chk("mid_rst_pad_dout", pad_dout, 0);
        chk("mid_rst_pad_vld", pad_dout_vld, 0);
        chk("mid_rst_pad_sof", pad_dout_sof, 0);
        chk("mid_rst_ovf", ofifo_ovf, 0);
        chk("mid_rst_err", in_frame_err, 0);
        pad_dout_rdy = 1;
        for (int t = 0; t < 4; t++) begin
            cycle();
            chk("post_rst_fifo_empty", pad_dout_vld, 0);
        end
        for (int k = 0; k < 5; k++) begin
            pad_din_vld = 1; pad_din_sof = (k == 0); pad_din = 16'h0D00 + 16'(k);
            cycle();
        end
        pad_din_vld = 0; pad_din_sof = 0;
        cycle();
        chk("post_rst_word_vld", core_d_vld, 1);
        chk("post_rst_word", core_d, 80'h0D04_0D03_0D02_0D01_0D00);
        chk("post_rst_err", in_frame_err, 0);
        cycle();

        // Random input beats against a beat-queue framing model.
        exp_d = 80'h0D04_0D03_0D02_0D01_0D00;
        err_exp = 0; done_prev = 0; word_prev = '0;
        for (int i = 0; i < 300; i++) begin
            pad_din_vld = ($urandom_range(0, 3) != 0);
            pad_din_sof = (mq.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            pad_din     = 16'($urandom());
            done_now = 0;
            word_now = word_prev;
            if (pad_din_vld) begin
                if (pad_din_sof) begin
                    if (mq.size() != 0) err_exp = 1;
                    mq.delete();
                    mq.push_back(pad_din);
                end else if (mq.size() == 0) begin
                    err_exp = 1;
                end else begin
                    mq.push_back(pad_din);
                end
                if (mq.size() == 5) begin
                    word_now = '0;
                    for (int k = 0; k < 5; k++) word_now[k*16 +: 16] = mq[k];
                    mq.delete();
                    done_now = 1;
                end
            end
            cycle();
            chk("rnd_d_vld", core_d_vld, done_prev);
            if (done_prev) exp_d = word_prev;
            chk("rnd_d", core_d, exp_d);
            chk("rnd_err", in_frame_err, err_exp);
            done_prev = done_now;
            word_prev = word_now;
        end
        pad_din_vld = 0; pad_din_sof = 0;
        cycle();
        chk("rnd_tail_vld", core_d_vld, done_prev);
        if (done_prev) exp_d = word_prev;
        chk("rnd_tail_d", core_d, exp_d);

        // Stray continuation beat with no preceding sof.
        reset_pulse();
        pad_din_vld = 1; pad_din_sof = 0; pad_din = 16'h0E0E;
        cycle();
        pad_din_vld = 0;
        chk("stray_err", in_frame_err, 1);
        cycle();
        cycle();
        chk("stray_no_word", core_d_vld, 0);
        chk("stray_core_d", core_d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
